// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM states, access owner, and the
// starvation-override grant decision.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_DMA  = 1'b1
    } arb_owner_t;

    // The core normally wins; dma wins when alone or once it has been starved.
    function automatic logic dma_wins(input logic core_req,
                                      input logic dma_req,
                                      input logic starved);
        return dma_req && (!core_req || starved);
    endfunction

endpackage

// File: rtl/dmem_arbiter_lat_counter.sv
// Loadable down-counter that times the fixed memory read latency and flags the
// cycle in which the read data is valid.
module arb_lat_counter #(
    parameter int LATENCY = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic dec,
    output logic last
);

    localparam int CW = $clog2(LATENCY + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CW'(LATENCY);
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last = (cnt_q == CW'(1));

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single data memory between the MW-stage core port and a dma master,
// sequencing each access IDLE -> ISSUE -> WAIT -> RESP through a fixed-latency memory.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int DW       = 32,
    parameter int LATENCY  = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [DW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    input  logic [2:0]    core_size,
    output logic          core_stall,
    output logic [DW-1:0] core_rdata,
    output logic          core_rvalid,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [DW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    input  logic [2:0]    dma_size,
    output logic          dma_gnt,
    output logic [DW-1:0] dma_rdata,
    output logic          dma_rvalid,
    output logic          mem_wr_en,
    output logic          mem_rd_en,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [2:0]    mem_size,
    input  logic [DW-1:0] mem_rdata
);

    localparam int WCW = $clog2(MAX_WAIT + 1);

    arb_state_t     state_q, state_d;
    arb_owner_t     owner_q, owner_d;
    logic           we_q, we_d;
    logic [DW-1:0]  addr_q, addr_d;
    logic [DW-1:0]  wdata_q, wdata_d;
    logic [2:0]     size_q, size_d;
    logic [DW-1:0]  rdata_q, rdata_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;

    logic lat_load;
    logic lat_dec;
    logic lat_last;
    logic dma_win;
    logic in_resp;

    arb_lat_counter #(
        .LATENCY (LATENCY)
    ) u_lat_counter (
        .clk   (clk),
        .reset (reset),
        .load  (lat_load),
        .dec   (lat_dec),
        .last  (lat_last)
    );

    assign dma_win = dma_wins(core_req, dma_req, wait_cnt_q == WCW'(MAX_WAIT));

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        size_d     = size_q;
        rdata_d    = rdata_q;
        wait_cnt_d = wait_cnt_q;
        lat_load   = 1'b0;
        lat_dec    = 1'b0;
        dma_gnt    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (core_req || dma_req) begin
                    state_d = ISSUE;
                    if (dma_win) begin
                        owner_d    = OWN_DMA;
                        we_d       = dma_we;
                        addr_d     = dma_addr;
                        wdata_d    = dma_wdata;
                        size_d     = dma_size;
                        dma_gnt    = 1'b1;
                        wait_cnt_d = '0;
                    end else begin
                        owner_d = OWN_CORE;
                        we_d    = core_we;
                        addr_d  = core_addr;
                        wdata_d = core_wdata;
                        size_d  = core_size;
                        // Each arbitration the dma loses brings it closer to a forced win.
                        if (dma_req && (wait_cnt_q != WCW'(MAX_WAIT))) begin
                            wait_cnt_d = wait_cnt_q + 1'b1;
                        end
                    end
                end
            end
            ISSUE: begin
                lat_load = 1'b1;
                state_d  = WAIT;
            end
            WAIT: begin
                lat_dec = 1'b1;
                if (lat_last) begin
                    rdata_d = mem_rdata;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            owner_q    <= OWN_CORE;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            size_q     <= '0;
            rdata_q    <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            size_q     <= size_d;
            rdata_q    <= rdata_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Memory-side fields come only from the latches so they stay put while inputs move.
    assign mem_rd_en = (state_q == ISSUE) && !we_q;
    assign mem_wr_en = (state_q == ISSUE) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_size  = size_q;

    assign in_resp     = (state_q == RESP);
    assign core_rvalid = in_resp && (owner_q == OWN_CORE);
    assign dma_rvalid  = in_resp && (owner_q == OWN_DMA);
    assign core_rdata  = (core_rvalid && !we_q) ? rdata_q : '0;
    assign dma_rdata   = (dma_rvalid && !we_q) ? rdata_q : '0;
    assign core_stall  = core_req && !core_rvalid;

endmodule
